// File: rtl/rs_issue_sched_pkg.sv
// Shared types for the reservation-station issue scheduler: tags, opcodes and
// the per-entry record held in the station.
package rs_issue_sched_pkg;
  localparam int TAG_W = 6;
  localparam int OP_W  = 7;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [OP_W-1:0]  opcode_t;

  typedef struct packed {
    opcode_t op;
    tag_t    T;
    tag_t    T1;
    logic    rdy1;
    tag_t    T2;
    logic    rdy2;
    logic    busy;
  } rs_entry_t;
endpackage

// File: rtl/rs_issue_sched_if.sv
// Dispatch, CDB, FU issue and occupancy signals of the issue scheduler.
// The scheduler uses the slave modport; its driver uses master.
interface rs_issue_sched_if #(parameter int NUM_RS = 4);
  import rs_issue_sched_pkg::*;
  localparam int CNT_W = $clog2(NUM_RS + 1);

  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  opcode_t          disp_op;
  tag_t             disp_T;
  tag_t             disp_T1;
  logic             disp_T1_rdy;
  tag_t             disp_T2;
  logic             disp_T2_rdy;
  logic             cdb_valid;
  tag_t             cdb_tag;
  logic             fu_ready;
  logic             issue_valid;
  opcode_t          issue_op;
  tag_t             issue_T;
  tag_t             issue_T1;
  tag_t             issue_T2;
  logic [CNT_W-1:0] rs_count;
  logic             rs_full;

  modport master (
    output flush, disp_valid, disp_op, disp_T, disp_T1, disp_T1_rdy, disp_T2, disp_T2_rdy,
           cdb_valid, cdb_tag, fu_ready,
    input  disp_ready, issue_valid, issue_op, issue_T, issue_T1, issue_T2, rs_count, rs_full
  );

  modport slave (
    input  flush, disp_valid, disp_op, disp_T, disp_T1, disp_T1_rdy, disp_T2, disp_T2_rdy,
           cdb_valid, cdb_tag, fu_ready,
    output disp_ready, issue_valid, issue_op, issue_T, issue_T1, issue_T2, rs_count, rs_full
  );
endinterface

// File: rtl/rs_issue_sched_age_matrix.sv
// Age matrix: older[i][j] means entry i was allocated before entry j.
// Grants the single eligible entry that no other eligible entry is older than.
module rs_age_matrix #(parameter int NUM_RS = 4) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_RS-1:0] alloc,
  input  logic [NUM_RS-1:0] free,
  input  logic [NUM_RS-1:0] eligible,
  output logic [NUM_RS-1:0] grant
);
  logic [NUM_RS-1:0] older [NUM_RS];

  // A new entry is younger than everyone; a freed entry stops claiming seniority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_RS; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        for (int j = 0; j < NUM_RS; j++) begin
          if (alloc[i])
            older[i][j] <= 1'b0;
          else if (alloc[j] && (i != j))
            older[i][j] <= 1'b1;
          else if (free[i])
            older[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      grant[i] = eligible[i];
      for (int j = 0; j < NUM_RS; j++)
        if (eligible[j] && older[j][i]) grant[i] = 1'b0;
    end
  end
endmodule

// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: holds dispatched ops, wakes operands on
// CDB broadcasts and issues the oldest ready entry through a registered FU stage.
module rs_issue_sched
  import rs_issue_sched_pkg::*;
#(parameter int NUM_RS = 4)
(
  input  logic             clk,
  input  logic             reset,
  rs_issue_sched_if.slave  bus
);
  localparam int CNT_W = $clog2(NUM_RS + 1);

  rs_entry_t         entries [NUM_RS];
  logic [NUM_RS-1:0] eligible, free_oh, alloc_oh, grant, issue_oh;
  logic [CNT_W-1:0]  count_q;
  logic              issue_valid_q;
  opcode_t           issue_op_q, sel_op;
  tag_t              issue_T_q, issue_T1_q, issue_T2_q, sel_T, sel_T1, sel_T2;
  logic              full, disp_fire, load, issue_fire, disp_rdy1, disp_rdy2;

  assign full      = (count_q == CNT_W'(NUM_RS));
  assign disp_fire = bus.disp_valid && !full && !bus.flush;
  assign alloc_oh  = disp_fire ? free_oh : '0;
  assign load      = !issue_valid_q || bus.fu_ready;
  assign issue_oh  = load ? grant : '0;
  assign issue_fire = |issue_oh;
  assign disp_rdy1 = bus.disp_T1_rdy || (bus.cdb_valid && (bus.cdb_tag == bus.disp_T1));
  assign disp_rdy2 = bus.disp_T2_rdy || (bus.cdb_valid && (bus.cdb_tag == bus.disp_T2));

  // Eligibility looks only at registered ready bits, so a wakeup costs a cycle.
  always_comb begin
    eligible = '0;
    free_oh  = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      eligible[i] = entries[i].busy && entries[i].rdy1 && entries[i].rdy2;
      if (!entries[i].busy && (free_oh == '0)) free_oh[i] = 1'b1;
    end
  end

  always_comb begin
    sel_op = '0;
    sel_T  = '0;
    sel_T1 = '0;
    sel_T2 = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (issue_oh[i]) begin
        sel_op = entries[i].op;
        sel_T  = entries[i].T;
        sel_T1 = entries[i].T1;
        sel_T2 = entries[i].T2;
      end
    end
  end

  rs_age_matrix #(.NUM_RS(NUM_RS)) u_age (
    .clk      (clk),
    .reset    (reset),
    .alloc    (alloc_oh),
    .free     (issue_oh),
    .eligible (eligible),
    .grant    (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_RS; i++) entries[i] <= '0;
      issue_valid_q <= 1'b0;
      issue_op_q    <= '0;
      issue_T_q     <= '0;
      issue_T1_q    <= '0;
      issue_T2_q    <= '0;
      count_q       <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_RS; i++) entries[i].busy <= 1'b0;
      issue_valid_q <= 1'b0;
      count_q       <= '0;
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (alloc_oh[i]) begin
          entries[i] <= '{op: bus.disp_op, T: bus.disp_T, T1: bus.disp_T1, rdy1: disp_rdy1,
                          T2: bus.disp_T2, rdy2: disp_rdy2, busy: 1'b1};
        end else if (entries[i].busy) begin
          if (issue_oh[i]) entries[i].busy <= 1'b0;
          if (bus.cdb_valid && (bus.cdb_tag == entries[i].T1)) entries[i].rdy1 <= 1'b1;
          if (bus.cdb_valid && (bus.cdb_tag == entries[i].T2)) entries[i].rdy2 <= 1'b1;
        end
      end
      if (load) begin
        issue_valid_q <= issue_fire;
        if (issue_fire) begin
          issue_op_q <= sel_op;
          issue_T_q  <= sel_T;
          issue_T1_q <= sel_T1;
          issue_T2_q <= sel_T2;
        end
      end
      case ({disp_fire, issue_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.disp_ready  = !full && !bus.flush;
  assign bus.rs_full     = full;
  assign bus.rs_count    = count_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_op    = issue_op_q;
  assign bus.issue_T     = issue_T_q;
  assign bus.issue_T1    = issue_T1_q;
  assign bus.issue_T2    = issue_T2_q;
endmodule
